// File: rtl/cpu_pkg.sv
// Shared encodings for the 8-bit CPU: sequencer states, opcodes, ALU and bus select codes.
// Decode helpers let the controller classify an opcode in one place.
package cpu_pkg;

    typedef enum logic [3:0] {
        S_FETCH0 = 4'd0,
        S_FETCH1 = 4'd1,
        S_FETCH2 = 4'd2,
        S_DECODE = 4'd3,
        S_OP0    = 4'd4,
        S_OP1    = 4'd5,
        S_OP2    = 4'd6,
        S_OP3    = 4'd7,
        S_OP4    = 4'd8,
        S_HALT   = 4'd9
    } state_t;

    localparam logic [7:0] OP_LDA_IMM = 8'h86;
    localparam logic [7:0] OP_LDA_DIR = 8'h87;
    localparam logic [7:0] OP_LDB_IMM = 8'h88;
    localparam logic [7:0] OP_LDB_DIR = 8'h89;
    localparam logic [7:0] OP_STA_DIR = 8'h96;
    localparam logic [7:0] OP_STB_DIR = 8'h97;
    localparam logic [7:0] OP_ADD_AB  = 8'h42;
    localparam logic [7:0] OP_SUB_AB  = 8'h43;
    localparam logic [7:0] OP_AND_AB  = 8'h44;
    localparam logic [7:0] OP_OR_AB   = 8'h45;
    localparam logic [7:0] OP_INCA    = 8'h46;
    localparam logic [7:0] OP_INCB    = 8'h47;
    localparam logic [7:0] OP_DECA    = 8'h48;
    localparam logic [7:0] OP_DECB    = 8'h49;
    localparam logic [7:0] OP_BRA     = 8'h20;
    localparam logic [7:0] OP_BMI     = 8'h21;
    localparam logic [7:0] OP_BEQ     = 8'h23;
    localparam logic [7:0] OP_BNE     = 8'h24;
    localparam logic [7:0] OP_BVS     = 8'h25;
    localparam logic [7:0] OP_BCS     = 8'h27;
    localparam logic [7:0] OP_HALT    = 8'hFF;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_INC = 3'b100;
    localparam logic [2:0] ALU_DEC = 3'b101;

    localparam logic [1:0] BUS1_PC = 2'b00;
    localparam logic [1:0] BUS1_A  = 2'b01;
    localparam logic [1:0] BUS1_B  = 2'b10;

    localparam logic [1:0] BUS2_ALU  = 2'b00;
    localparam logic [1:0] BUS2_BUS1 = 2'b01;
    localparam logic [1:0] BUS2_MEM  = 2'b10;

    function automatic logic is_ld_imm(input logic [7:0] op);
        return (op == OP_LDA_IMM) || (op == OP_LDB_IMM);
    endfunction

    function automatic logic is_ld_dir(input logic [7:0] op);
        return (op == OP_LDA_DIR) || (op == OP_LDB_DIR);
    endfunction

    function automatic logic is_store(input logic [7:0] op);
        return (op == OP_STA_DIR) || (op == OP_STB_DIR);
    endfunction

    function automatic logic is_alu_ab(input logic [7:0] op);
        return (op == OP_ADD_AB) || (op == OP_SUB_AB) || (op == OP_AND_AB) || (op == OP_OR_AB);
    endfunction

    function automatic logic is_incdec(input logic [7:0] op);
        return (op == OP_INCA) || (op == OP_INCB) || (op == OP_DECA) || (op == OP_DECB);
    endfunction

    function automatic logic is_branch(input logic [7:0] op);
        return (op == OP_BRA) || (op == OP_BMI) || (op == OP_BEQ) ||
               (op == OP_BNE) || (op == OP_BVS) || (op == OP_BCS);
    endfunction

    function automatic logic is_known(input logic [7:0] op);
        return is_ld_imm(op) || is_ld_dir(op) || is_store(op) ||
               is_alu_ab(op) || is_incdec(op) || is_branch(op);
    endfunction

    function automatic logic [2:0] alu_sel_of(input logic [7:0] op);
        logic [2:0] sel;
        case (op)
            OP_SUB_AB:        sel = ALU_SUB;
            OP_AND_AB:        sel = ALU_AND;
            OP_OR_AB:         sel = ALU_OR;
            OP_INCA, OP_INCB: sel = ALU_INC;
            OP_DECA, OP_DECB: sel = ALU_DEC;
            default:          sel = ALU_ADD;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/branch_cond.sv
// Branch condition evaluator: decides from the opcode and the {N,Z,V,C} flags whether a branch is taken.
// Non-branch opcodes always report not-taken.
module branch_cond
    import cpu_pkg::*;
(
    input  logic [7:0] i_ir,
    input  logic [3:0] i_nzvc,
    output logic       o_taken
);

    always_comb begin
        o_taken = 1'b0;
        case (i_ir)
            OP_BRA:  o_taken = 1'b1;
            OP_BMI:  o_taken = i_nzvc[3];
            OP_BEQ:  o_taken = i_nzvc[2];
            OP_BNE:  o_taken = ~i_nzvc[2];
            OP_BVS:  o_taken = i_nzvc[1];
            OP_BCS:  o_taken = i_nzvc[0];
            default: o_taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/control_unit.sv
// Moore fetch-decode-execute sequencer driving every datapath strobe and the memory write.
// The FSM state is exported on o_dbg_state; all other outputs are held at 0 while reset is high.
module control_unit
    import cpu_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] IR,
    input  logic [3:0] CCR_Result,
    output logic       IR_Load,
    output logic       MAR_Load,
    output logic       PC_Load,
    output logic       PC_Inc,
    output logic       A_Load,
    output logic       B_Load,
    output logic [2:0] ALU_Sel,
    output logic       CCR_Load,
    output logic [1:0] Bus1_Sel,
    output logic [1:0] Bus2_Sel,
    output logic       write,
    output logic       halted,
    output state_t     o_dbg_state
);

    state_t r_state;
    state_t w_next_state;
    logic   r_taken;
    logic   w_taken;

    branch_cond u_branch_cond (
        .i_ir    (IR),
        .i_nzvc  (CCR_Result),
        .o_taken (w_taken)
    );

    assign o_dbg_state = r_state;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_FETCH0;
            r_taken <= 1'b0;
        end else begin
            r_state <= w_next_state;
            // Flags are sampled once in decode so the execute states see a stable decision.
            if (r_state == S_DECODE) begin
                r_taken <= w_taken;
            end
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_FETCH0: w_next_state = S_FETCH1;
            S_FETCH1: w_next_state = S_FETCH2;
            S_FETCH2: w_next_state = S_DECODE;
            S_DECODE: begin
                if (IR == OP_HALT) begin
                    w_next_state = S_HALT;
                end else if (is_known(IR)) begin
                    w_next_state = S_OP0;
                end else begin
                    w_next_state = S_FETCH0;
                end
            end
            S_OP0: begin
                if (is_alu_ab(IR) || is_incdec(IR) || (is_branch(IR) && !r_taken)) begin
                    w_next_state = S_FETCH0;
                end else begin
                    w_next_state = S_OP1;
                end
            end
            S_OP1:   w_next_state = S_OP2;
            S_OP2:   w_next_state = (is_ld_imm(IR) || is_branch(IR)) ? S_FETCH0 : S_OP3;
            S_OP3:   w_next_state = is_store(IR) ? S_FETCH0 : S_OP4;
            S_OP4:   w_next_state = S_FETCH0;
            S_HALT:  w_next_state = S_HALT;
            default: w_next_state = S_FETCH0;
        endcase
    end

    always_comb begin
        IR_Load  = 1'b0;
        MAR_Load = 1'b0;
        PC_Load  = 1'b0;
        PC_Inc   = 1'b0;
        A_Load   = 1'b0;
        B_Load   = 1'b0;
        ALU_Sel  = ALU_ADD;
        CCR_Load = 1'b0;
        Bus1_Sel = BUS1_PC;
        Bus2_Sel = BUS2_ALU;
        write    = 1'b0;
        halted   = 1'b0;
        if (!reset) begin
            case (r_state)
                S_FETCH0: begin
                    Bus1_Sel = BUS1_PC;
                    Bus2_Sel = BUS2_BUS1;
                    MAR_Load = 1'b1;
                end
                S_FETCH1: PC_Inc = 1'b1;
                S_FETCH2: begin
                    Bus2_Sel = BUS2_MEM;
                    IR_Load  = 1'b1;
                end
                S_OP0: begin
                    if (is_ld_imm(IR) || is_ld_dir(IR) || is_store(IR) ||
                        (is_branch(IR) && r_taken)) begin
                        Bus1_Sel = BUS1_PC;
                        Bus2_Sel = BUS2_BUS1;
                        MAR_Load = 1'b1;
                    end else if (is_branch(IR)) begin
                        PC_Inc = 1'b1;
                    end else if (is_alu_ab(IR) || is_incdec(IR)) begin
                        Bus1_Sel = (IR == OP_INCB || IR == OP_DECB) ? BUS1_B : BUS1_A;
                        Bus2_Sel = BUS2_ALU;
                        ALU_Sel  = alu_sel_of(IR);
                        CCR_Load = 1'b1;
                        if (IR == OP_INCB || IR == OP_DECB) begin
                            B_Load = 1'b1;
                        end else begin
                            A_Load = 1'b1;
                        end
                    end
                end
                S_OP1: begin
                    // Taken branches only wait here for the operand read.
                    if (is_ld_imm(IR) || is_ld_dir(IR) || is_store(IR)) begin
                        PC_Inc = 1'b1;
                    end
                end
                S_OP2: begin
                    Bus2_Sel = BUS2_MEM;
                    if (is_ld_imm(IR)) begin
                        A_Load = (IR == OP_LDA_IMM);
                        B_Load = (IR == OP_LDB_IMM);
                    end else if (is_ld_dir(IR) || is_store(IR)) begin
                        MAR_Load = 1'b1;
                    end else if (is_branch(IR)) begin
                        PC_Load = 1'b1;
                    end
                end
                S_OP3: begin
                    if (is_store(IR)) begin
                        Bus1_Sel = (IR == OP_STA_DIR) ? BUS1_A : BUS1_B;
                        write    = 1'b1;
                    end
                end
                S_OP4: begin
                    if (is_ld_dir(IR)) begin
                        Bus2_Sel = BUS2_MEM;
                        A_Load   = (IR == OP_LDA_DIR);
                        B_Load   = (IR == OP_LDB_DIR);
                    end
                end
                S_HALT:  halted = 1'b1;
                default: halted = 1'b0;
            endcase
        end
    end

endmodule

// File: tb/tb_control_unit.sv
// Bench for control_unit: a small datapath and memory model runs programs under the sequencer;
// a vector table covers each opcode, followed by hand-written reset, program, branch and halt sequences.
module tb_control_unit;
    import cpu_pkg::*;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] ir = 8'h00;
    logic [3:0] ccr = 4'h0;
    logic       IR_Load, MAR_Load, PC_Load, PC_Inc, A_Load, B_Load, CCR_Load, write, halted;
    logic [2:0] ALU_Sel;
    logic [1:0] Bus1_Sel, Bus2_Sel;
    state_t     dbg_state;

    control_unit dut (
        .clk         (clk),
        .reset       (reset),
        .IR          (ir),
        .CCR_Result  (ccr),
        .IR_Load     (IR_Load),
        .MAR_Load    (MAR_Load),
        .PC_Load     (PC_Load),
        .PC_Inc      (PC_Inc),
        .A_Load      (A_Load),
        .B_Load      (B_Load),
        .ALU_Sel     (ALU_Sel),
        .CCR_Load    (CCR_Load),
        .Bus1_Sel    (Bus1_Sel),
        .Bus2_Sel    (Bus2_Sel),
        .write       (write),
        .halted      (halted),
        .o_dbg_state (dbg_state)
    );

    always #5 clk = ~clk;

    wire [15:0] ctl = {IR_Load, MAR_Load, PC_Load, PC_Inc, A_Load, B_Load, ALU_Sel,
                       CCR_Load, Bus1_Sel, Bus2_Sel, write, halted};
    localparam logic [15:0] CTL_FETCH0 = 16'h4004;
    localparam logic [15:0] CTL_HALT   = 16'h0001;

    // Datapath model state, all owned by the single stimulus process.
    logic [7:0] mem [256];
    logic [7:0] pc, mar, a, b, fm;
    int         cyc, n_irl, n_pcl, n_wr, n_both, wr_cyc;
    logic [7:0] wr_mar;
    logic [1:0] wr_bus1;
    int         n_pass = 0;
    int         n_total = 0;

    typedef struct {
        logic [7:0] op;
        logic [7:0] opnd;
        logic [3:0] ccr_in;
        logic [7:0] a_in;
        logic [7:0] b_in;
        int         cycles;
        logic [7:0] pc_next;
        logic [7:0] a_exp;
        logic [7:0] b_exp;
        logic [3:0] ccr_exp;
        int         writes;
        int         pc_loads;
        logic [7:0] st_addr;
        logic [7:0] st_val;
    } vec_t;
    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // Samples the strobes at the falling edge, then applies them just after the rising edge.
    task automatic tick();
        logic [7:0] bus1, bus2, r, fm_n;
        logic [8:0] w;
        logic       v, c;
        logic [15:0] s;
        s = ctl;
        case (Bus1_Sel)
            BUS1_A:  bus1 = a;
            BUS1_B:  bus1 = b;
            default: bus1 = pc;
        endcase
        w = 9'd0; v = 1'b0; c = 1'b0;
        case (ALU_Sel)
            ALU_ADD: begin w = {1'b0, b} + {1'b0, bus1}; v = (b[7] == bus1[7]) && (w[7] != b[7]); end
            ALU_SUB: begin w = {1'b0, b} - {1'b0, bus1}; v = (b[7] != bus1[7]) && (w[7] != b[7]); end
            ALU_AND: w = {1'b0, b & bus1};
            ALU_OR:  w = {1'b0, b | bus1};
            ALU_INC: begin w = {1'b0, bus1} + 9'd1; v = (bus1 == 8'h7F); end
            ALU_DEC: begin w = {1'b0, bus1} - 9'd1; v = (bus1 == 8'h80); end
            default: w = 9'd0;
        endcase
        r = w[7:0];
        c = (ALU_Sel == ALU_AND || ALU_Sel == ALU_OR) ? 1'b0 : w[8];
        case (Bus2_Sel)
            BUS2_BUS1: bus2 = bus1;
            BUS2_MEM:  bus2 = fm;
            default:   bus2 = r;
        endcase
        cyc++;
        if (IR_Load) n_irl++;
        if (PC_Load) n_pcl++;
        if (PC_Load && PC_Inc) n_both++;
        if (write) begin
            n_wr++; wr_cyc = cyc; wr_mar = mar; wr_bus1 = Bus1_Sel;
        end
        @(posedge clk);
        #1;
        fm_n = mem[mar];
        if (s[1]) mem[mar] = bus1;
        fm = fm_n;
        if (s[14]) mar = bus2;
        if (s[13]) pc = bus2;
        else if (s[12]) pc = pc + 8'd1;
        if (s[15]) ir = bus2;
        if (s[11]) a = bus2;
        if (s[10]) b = bus2;
        if (s[6]) ccr = {r[7], (r == 8'h00), v, c};
        @(negedge clk);
    endtask

    // Clears the model and holds reset for two cycles; the caller loads its program and releases reset.
    task automatic prep();
        reset = 1'b1;
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        mem[8'h40] = 8'hC3;
        mem[8'h41] = 8'h3C;
        pc = 8'h00; mar = 8'h00; a = 8'h00; b = 8'h00; fm = 8'h00; ir = 8'h00; ccr = 4'h0;
        tick();
        tick();
        cyc = 0; n_irl = 0; n_pcl = 0; n_wr = 0; n_both = 0; wr_cyc = 0;
        wr_mar = 8'h00; wr_bus1 = 2'b00;
    endtask

    initial begin
        int first, second, prev;
        string nm;

        vecs.push_back(vec_t'{8'h86, 8'h5A, 4'h0, 8'h00, 8'h00, 7, 8'h02, 8'h5A, 8'h00, 4'h0, 0, 0, 8'h00, 8'h00});
        vecs.push_back(vec_t'{8'h88, 8'h03, 4'h0, 8'h00, 8'h00, 7, 8'h02, 8'h00, 8'h03, 4'h0, 0, 0, 8'h00, 8'h00});
        vecs.push_back(vec_t'{8'h87, 8'h40, 4'h0, 8'h00, 8'h00, 9, 8'h02, 8'hC3, 8'h00, 4'h0, 0, 0, 8'h00, 8'h00});
        vecs.push_back(vec_t'{8'h89, 8'h41, 4'h0, 8'h00, 8'h00, 9, 8'h02, 8'h00, 8'h3C, 4'h0, 0, 0, 8'h00, 8'h00});
        vecs.push_back(vec_t'{8'h96, 8'hE0, 4'h0, 8'h77, 8'h00, 8, 8'h02, 8'h77, 8'h00, 4'h0, 1, 0, 8'hE0, 8'h77});
        vecs.push_back(vec_t'{8'h97, 8'hE1, 4'h0, 8'h00, 8'h21, 8, 8'h02, 8'h00, 8'h21, 4'h0, 1, 0, 8'hE1, 8'h21});
        vecs.push_back(vec_t'{8'h42, 8'h00, 4'hF, 8'h5A, 8'h03, 5, 8'h01, 8'h5D, 8'h03, 4'h0, 0, 0, 8'h00, 8'h00});
        vecs.push_back(vec_t'{8'h43, 8'h00, 4'h0, 8'h05, 8'h03, 5, 8'h01, 8'hFE, 8'h03, 4'h9, 0, 0, 8'h00, 8'h00});
        vecs.push_back(vec_t'{8'h44, 8'h00, 4'h0, 8'hF0, 8'h0F, 5, 8'h01, 8'h00, 8'h0F, 4'h4, 0, 0, 8'h00, 8'h00});
        vecs.push_back(vec_t'{8'h45, 8'h00, 4'h0, 8'h80, 8'h01, 5, 8'h01, 8'h81, 8'h01, 4'h8, 0, 0, 8'h00, 8'h00});
        vecs.push_back(vec_t'{8'h46, 8'h00, 4'h0, 8'h7F, 8'h00, 5, 8'h01, 8'h80, 8'h00, 4'hA, 0, 0, 8'h00, 8'h00});
        vecs.push_back(vec_t'{8'h48, 8'h00, 4'h0, 8'h01, 8'h00, 5, 8'h01, 8'h00, 8'h00, 4'h4, 0, 0, 8'h00, 8'h00});
        vecs.push_back(vec_t'{8'h47, 8'h00, 4'h0, 8'h00, 8'hFF, 5, 8'h01, 8'h00, 8'h00, 4'h5, 0, 0, 8'h00, 8'h00});
        vecs.push_back(vec_t'{8'h49, 8'h00, 4'h0, 8'h00, 8'h00, 5, 8'h01, 8'h00, 8'hFF, 4'h9, 0, 0, 8'h00, 8'h00});
        vecs.push_back(vec_t'{8'h20, 8'h10, 4'h0, 8'h00, 8'h00, 7, 8'h10, 8'h00, 8'h00, 4'h0, 0, 1, 8'h00, 8'h00});
        vecs.push_back(vec_t'{8'h20, 8'h10, 4'hF, 8'h00, 8'h00, 7, 8'h10, 8'h00, 8'h00, 4'hF, 0, 1, 8'h00, 8'h00});
        vecs.push_back(vec_t'{8'h21, 8'h10, 4'h8, 8'h00, 8'h00, 7, 8'h10, 8'h00, 8'h00, 4'h8, 0, 1, 8'h00, 8'h00});
        vecs.push_back(vec_t'{8'h21, 8'h10, 4'h7, 8'h00, 8'h00, 5, 8'h02, 8'h00, 8'h00, 4'h7, 0, 0, 8'h00, 8'h00});
        vecs.push_back(vec_t'{8'h23, 8'h10, 4'h4, 8'h00, 8'h00, 7, 8'h10, 8'h00, 8'h00, 4'h4, 0, 1, 8'h00, 8'h00});
        vecs.push_back(vec_t'{8'h23, 8'h10, 4'hB, 8'h00, 8'h00, 5, 8'h02, 8'h00, 8'h00, 4'hB, 0, 0, 8'h00, 8'h00});
        vecs.push_back(vec_t'{8'h24, 8'h10, 4'h0, 8'h00, 8'h00, 7, 8'h10, 8'h00, 8'h00, 4'h0, 0, 1, 8'h00, 8'h00});
        vecs.push_back(vec_t'{8'h24, 8'h10, 4'h4, 8'h00, 8'h00, 5, 8'h02, 8'h00, 8'h00, 4'h4, 0, 0, 8'h00, 8'h00});
        vecs.push_back(vec_t'{8'h25, 8'h10, 4'h2, 8'h00, 8'h00, 7, 8'h10, 8'h00, 8'h00, 4'h2, 0, 1, 8'h00, 8'h00});
        vecs.push_back(vec_t'{8'h25, 8'h10, 4'hD, 8'h00, 8'h00, 5, 8'h02, 8'h00, 8'h00, 4'hD, 0, 0, 8'h00, 8'h00});
        vecs.push_back(vec_t'{8'h27, 8'h10, 4'h1, 8'h00, 8'h00, 7, 8'h10, 8'h00, 8'h00, 4'h1, 0, 1, 8'h00, 8'h00});
        vecs.push_back(vec_t'{8'h27, 8'h10, 4'hE, 8'h00, 8'h00, 5, 8'h02, 8'h00, 8'h00, 4'hE, 0, 0, 8'h00, 8'h00});
        vecs.push_back(vec_t'{8'h00, 8'h00, 4'h0, 8'h00, 8'h00, 4, 8'h01, 8'h00, 8'h00, 4'h0, 0, 0, 8'h00, 8'h00});
        vecs.push_back(vec_t'{8'h22, 8'h00, 4'h0, 8'h00, 8'h00, 4, 8'h01, 8'h00, 8'h00, 4'h0, 0, 0, 8'h00, 8'h00});

        @(negedge clk);

        // One instruction per vector; its length is the gap between its IR_Load and the next one.
        for (int i = 0; i < vecs.size(); i++) begin
            prep();
            mem[0] = vecs[i].op;
            mem[1] = vecs[i].opnd;
            a = vecs[i].a_in; b = vecs[i].b_in; ccr = vecs[i].ccr_in;
            reset = 1'b0;
            first = -1; second = -1;
            for (int k = 0; k < 40 && second < 0; k++) begin
                prev = n_irl;
                tick();
                if (n_irl != prev) begin
                    if (first < 0) first = cyc;
                    else second = cyc;
                end
            end
            nm = $sformatf("v%0d op%02h", i, vecs[i].op);
            check({nm, " next fetch seen"}, (second >= 0) ? 32'd1 : 32'd0, 32'd1);
            check({nm, " cycles"}, second - first, vecs[i].cycles);
            // The following fetch has already incremented PC once when its IR_Load occurs.
            check({nm, " pc"}, pc, vecs[i].pc_next + 8'd1);
            check({nm, " a"}, a, vecs[i].a_exp);
            check({nm, " b"}, b, vecs[i].b_exp);
            check({nm, " ccr"}, ccr, vecs[i].ccr_exp);
            check({nm, " write cycles"}, n_wr, vecs[i].writes);
            check({nm, " pc_load cycles"}, n_pcl, vecs[i].pc_loads);
            check({nm, " pc_load with pc_inc"}, n_both, 0);
            if (vecs[i].writes == 1) begin
                check({nm, " write cycle index"}, wr_cyc, 8);
                check({nm, " write mar"}, wr_mar, vecs[i].st_addr);
                check({nm, " write bus1"}, wr_bus1, (vecs[i].op == OP_STA_DIR) ? BUS1_A : BUS1_B);
                check({nm, " mem"}, mem[vecs[i].st_addr], vecs[i].st_val);
            end
        end

        // Reset held three cycles in the middle of LDA_DIR.
        prep();
        mem[0] = OP_LDA_DIR; mem[1] = 8'h40;
        reset = 1'b0;
        for (int k = 0; k < 5; k++) tick();
        check("mid-instruction state before reset", dbg_state, S_OP1);
        reset = 1'b1;
        #1;
        for (int k = 0; k < 3; k++) begin
            check($sformatf("outputs zero in reset cycle %0d", k), ctl, 16'h0000);
            tick();
        end
        reset = 1'b0;
        #1;
        check("first cycle after reset is fetch0", ctl, CTL_FETCH0);
        check("state after reset", dbg_state, S_FETCH0);
        check("a untouched by abandoned load", a, 8'h00);

        // Three-instruction program.
        prep();
        mem[0] = 8'h86; mem[1] = 8'h5A; mem[2] = 8'h88; mem[3] = 8'h03; mem[4] = 8'h42;
        reset = 1'b0;
        for (int k = 0; k < 7; k++) tick();
        check("prog a after 7", a, 8'h5A);
        for (int k = 0; k < 7; k++) tick();
        check("prog b after 14", b, 8'h03);
        for (int k = 0; k < 5; k++) tick();
        check("prog a after 19", a, 8'h5D);
        check("prog ccr after 19", ccr, 4'h0);
        check("prog ir_load count", n_irl, 3);

        // DECA sets Z, BEQ then takes it and BNE falls through.
        prep();
        mem[0] = OP_DECA; mem[1] = OP_BEQ; mem[2] = 8'h10;
        mem[8'h10] = OP_BNE; mem[8'h11] = 8'h30;
        a = 8'h01;
        reset = 1'b0;
        for (int k = 0; k < 12; k++) tick();
        check("deca-beq pc after 12", pc, 8'h10);
        for (int k = 0; k < 5; k++) tick();
        check("deca-beq-bne a", a, 8'h00);
        check("deca-beq-bne ccr", ccr, 4'h4);
        check("deca-beq-bne pc", pc, 8'h12);
        check("deca-beq-bne pc_load count", n_pcl, 1);

        // HALT holds with only halted asserted until reset.
        prep();
        mem[0] = OP_HALT;
        reset = 1'b0;
        for (int k = 0; k < 4; k++) tick();
        check("halt state", dbg_state, S_HALT);
        for (int k = 0; k < 20; k++) begin
            check($sformatf("halt outputs cycle %0d", k), ctl, CTL_HALT);
            tick();
        end
        check("halt pc frozen", pc, 8'h01);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        check("halt cleared by reset", ctl, CTL_FETCH0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
